// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon sequencer slice.
package simon_pkg;

    // Colour codes understood by colour_encoder
    localparam logic [1:0] COL_RED    = 2'b00;
    localparam logic [1:0] COL_BLUE   = 2'b01;
    localparam logic [1:0] COL_YELLOW = 2'b10;
    localparam logic [1:0] COL_GREEN  = 2'b11;

    // Playback sequencer states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_GAP,
        ST_DONE
    } state_t;

    // x^8+x^6+x^5+x^4+1 taps map to bits 7,5,4,3 when shifting left
    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/simon_playback_ctrl_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used as the colour source.
module colour_lfsr
    import simon_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] lfsr
);

    // Advance every cycle; reload the seed on reset
    always_ff @(posedge clk) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= lfsr_next(lfsr);
    end

endmodule

// File: rtl/simon_playback_ctrl.sv
// Colour-sequence store and timed playback sequencer.
module simon_playback_ctrl
    import simon_pkg::*;
#(
    parameter int MAX_LEN    = 16,
    parameter int ON_CYCLES  = 12_000_000,
    parameter int OFF_CYCLES = 4_000_000,
    localparam int AW        = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          append,
    input  logic          play,
    input  logic [AW-1:0] rd_idx,
    output logic [1:0]    rd_colour,
    output logic [1:0]    colour,
    output logic          led_en,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   seq_len,
    output logic          full
);

    localparam int CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] idx, idx_n;
    logic [AW:0]   len_n;
    logic          wr_en;
    logic [7:0]    lfsr;
    logic [5:0]    unused_lfsr_hi;
    logic [1:0]    mem [MAX_LEN];

    colour_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    assign unused_lfsr_hi = lfsr[7:2];
    assign rd_colour      = mem[rd_idx];
    // MAX_LEN is a power of two, so the top bit of seq_len alone marks full
    assign full           = seq_len[AW];

    // Next-state, counter, index and length update
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        len_n   = seq_len;
        wr_en   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (clear) begin
                    len_n = '0;
                end else if (append) begin
                    if (!full) begin
                        wr_en = 1'b1;
                        len_n = seq_len + (AW+1)'(1);
                    end
                end else if (play) begin
                    if (seq_len == '0) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_ON;
                        idx_n   = '0;
                        cnt_n   = '0;
                    end
                end
            end
            ST_ON: begin
                if (cnt == CW'(ON_CYCLES - 1)) begin
                    state_n = ST_GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt == CW'(OFF_CYCLES - 1)) begin
                    cnt_n = '0;
                    if ((AW+1)'(idx) == seq_len - (AW+1)'(1)) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_ON;
                        idx_n   = idx + AW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // State, counters and outputs; outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            seq_len <= '0;
            colour  <= COL_RED;
            led_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            seq_len <= len_n;
            colour  <= (state_n == ST_ON) ? mem[idx_n] : COL_RED;
            led_en  <= (state_n == ST_ON);
            busy    <= (state_n != ST_IDLE);
            done    <= (state_n == ST_DONE);
        end
    end

    // Sequence storage; not reset, seq_len alone marks valid entries
    always_ff @(posedge clk) begin
        if (wr_en) mem[seq_len[AW-1:0]] <= lfsr[1:0];
    end

endmodule

// File: tb/tb_simon_playback_ctrl.sv
// Directed bench for simon_playback_ctrl (MAX_LEN=4, ON=3, OFF=2).
module tb_simon_playback_ctrl;

    localparam int MAX_LEN = 4;
    localparam int ON_C    = 3;
    localparam int OFF_C   = 2;
    localparam int PER     = ON_C + OFF_C;

    logic       clk = 1'b0;
    logic       rst, clear, append, play;
    logic [1:0] rd_idx;
    logic [1:0] rd_colour, colour;
    logic       led_en, busy, done, full;
    logic [2:0] seq_len;

    logic [7:0] m;
    logic [1:0] exp_col [4];
    int         errors = 0;
    int         checks = 0;

    simon_playback_ctrl #(
        .MAX_LEN    (MAX_LEN),
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .append    (append),
        .play      (play),
        .rd_idx    (rd_idx),
        .rd_colour (rd_colour),
        .colour    (colour),
        .led_en    (led_en),
        .busy      (busy),
        .done      (done),
        .seq_len   (seq_len),
        .full      (full)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed 01
    always @(posedge clk) begin
        if (rst) m <= 8'h01;
        else     m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    end

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Walk one full playback of n entries starting at cycle T+1
    task automatic check_playback(input int n, input string tag);
        for (int c = 1; c <= n * PER + 1; c++) begin
            int k, ph;
            k  = (c - 1) / PER;
            ph = (c - 1) % PER;
            if (c == n * PER + 1) begin
                chk({tag, " done"}, int'(done), 1);
                chk({tag, " busy_end"}, int'(busy), 1);
                chk({tag, " led_end"}, int'(led_en), 0);
            end else begin
                chk({tag, " led"}, int'(led_en), (ph < ON_C) ? 1 : 0);
                chk({tag, " colour"}, int'(colour), (ph < ON_C) ? int'(exp_col[k]) : 0);
                chk({tag, " busy"}, int'(busy), 1);
                chk({tag, " done_early"}, int'(done), 0);
            end
            step();
        end
        chk({tag, " busy_after"}, int'(busy), 0);
        chk({tag, " done_after"}, int'(done), 0);
    endtask

    task automatic do_append(input int slot);
        append = 1'b1;
        if (slot >= 0) exp_col[slot] = m[1:0];
        step();
        append = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; append = 1'b0; play = 1'b0; rd_idx = '0;
        step(); step();
        chk("rst colour", int'(colour), 0);
        chk("rst led", int'(led_en), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst len", int'(seq_len), 0);
        chk("rst full", int'(full), 0);
        rst = 1'b0;
        step();

        // Play on an empty sequence: single DONE cycle, no lamp
        play = 1'b1;
        step();
        play = 1'b0;
        chk("empty busy", int'(busy), 1);
        chk("empty done", int'(done), 1);
        chk("empty led", int'(led_en), 0);
        step();
        chk("empty busy2", int'(busy), 0);
        chk("empty done2", int'(done), 0);
        chk("empty led2", int'(led_en), 0);
        chk("empty len", int'(seq_len), 0);

        // Three back-to-back appends
        append = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_col[i] = m[1:0];
            step();
        end
        append = 1'b0;
        chk("app3 len", int'(seq_len), 3);
        chk("app3 full", int'(full), 0);
        for (int i = 0; i < 3; i++) begin
            rd_idx = 2'(i);
            #1;
            chk("app3 rd", int'(rd_colour), int'(exp_col[i]));
        end
        step();

        // Playback of 3 entries
        play = 1'b1;
        step();
        play = 1'b0;
        check_playback(3, "play3");

        // Fill to capacity; fifth append ignored
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear len", int'(seq_len), 0);
        for (int i = 0; i < 4; i++) begin
            do_append(i);
            chk("fill len", int'(seq_len), i + 1);
            chk("fill full", int'(full), (i == 3) ? 1 : 0);
        end
        do_append(-1);
        chk("over len", int'(seq_len), 4);
        chk("over full", int'(full), 1);
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            chk("over rd", int'(rd_colour), int'(exp_col[i]));
        end

        // append+play together: only the append acts
        clear = 1'b1;
        step();
        clear = 1'b0;
        do_append(0);
        do_append(1);
        append = 1'b1;
        play   = 1'b1;
        exp_col[2] = m[1:0];
        step();
        append = 1'b0;
        play   = 1'b0;
        chk("ap len", int'(seq_len), 3);
        chk("ap busy", int'(busy), 0);
        rd_idx = 2'd2;
        #1;
        chk("ap rd2", int'(rd_colour), int'(exp_col[2]));
        play = 1'b1;
        step();
        play = 1'b0;
        check_playback(3, "play_ext");

        // clear+append together: clear wins
        clear  = 1'b1;
        append = 1'b1;
        step();
        clear  = 1'b0;
        append = 1'b0;
        chk("ca len", int'(seq_len), 0);

        // Commands during busy are dropped; rst during second ON
        do_append(0);
        do_append(1);
        play = 1'b1;
        step();
        play = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 2) append = 1'b1;
            if (c == 3) begin append = 1'b0; clear = 1'b1; end
            if (c == 4) begin
                clear = 1'b0;
                chk("busy cmd len", int'(seq_len), 2);
            end
            if (c == 7) begin
                chk("on2 led", int'(led_en), 1);
                chk("on2 colour", int'(colour), int'(exp_col[1]));
                rst = 1'b1;
            end
            step();
        end
        rst = 1'b0;
        chk("mrst led", int'(led_en), 0);
        chk("mrst busy", int'(busy), 0);
        chk("mrst len", int'(seq_len), 0);
        chk("mrst colour", int'(colour), 0);
        chk("mrst full", int'(full), 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
